// File: rtl/nabp_sinogram_loader.sv
// Sinogram RAM front end for the NABP core: the host streams a full sinogram in,
// then the block kicks NABP, serves its 1-cycle-latency reads, and reports done.
module nabp_sinogram_loader #(
    parameter int DATA_LENGTH = 32,
    parameter int IMAGE_SIZE  = 128,
    parameter int NUM_ANGLES  = 180,
    parameter int ADDR_LENGTH = 15
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   load_start,
    input  logic [DATA_LENGTH-1:0] hs_val,
    input  logic                   hs_valid,
    output logic                   hs_ready,
    input  logic                   host_kick,
    output logic                   done,
    output logic                   loaded,
    output logic                   nabp_kick,
    input  logic                   nabp_done,
    input  logic [ADDR_LENGTH-1:0] sg_addr,
    output logic [DATA_LENGTH-1:0] sg_val
);

    localparam int N = NUM_ANGLES * IMAGE_SIZE;
    localparam int WP_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [WP_W-1:0] WP_LAST = WP_W'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LOADED,
        S_KICK,
        S_RUN
    } state_t;

    state_t            state, state_nxt;
    logic [WP_W-1:0]   wp, wp_nxt;
    logic              done_nxt;
    logic              nabp_done_q;
    logic              xfer;

    logic [DATA_LENGTH-1:0] mem [N];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            wp          <= '0;
            done        <= 1'b0;
            nabp_done_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            wp          <= wp_nxt;
            done        <= done_nxt;
            nabp_done_q <= nabp_done;
        end
    end

    always_comb begin
        state_nxt = state;
        wp_nxt    = wp;
        done_nxt  = 1'b0;
        hs_ready  = 1'b0;
        loaded    = 1'b0;
        nabp_kick = 1'b0;
        xfer      = 1'b0;
        case (state)
            S_IDLE: begin
                if (load_start) begin
                    state_nxt = S_LOAD;
                    wp_nxt    = '0;
                end
            end
            S_LOAD: begin
                hs_ready = 1'b1;
                xfer     = hs_valid;
                // A restart discards whatever this cycle wrote; wp just rewinds.
                if (load_start) begin
                    wp_nxt = '0;
                end else if (xfer) begin
                    if (wp == WP_LAST) begin
                        state_nxt = S_LOADED;
                        wp_nxt    = '0;
                    end else begin
                        wp_nxt = wp + 1'b1;
                    end
                end
            end
            S_LOADED: begin
                loaded = 1'b1;
                if (load_start) begin
                    state_nxt = S_LOAD;
                    wp_nxt    = '0;
                end else if (host_kick) begin
                    state_nxt = S_KICK;
                end
            end
            S_KICK: begin
                loaded    = 1'b1;
                nabp_kick = 1'b1;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                loaded = 1'b1;
                // Edge-detect so a level-high done left over from NABP can't re-fire.
                if (nabp_done && !nabp_done_q) begin
                    done_nxt  = 1'b1;
                    state_nxt = S_LOADED;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (xfer)
            mem[wp] <= hs_val;
    end

    logic [WP_W-1:0] rd_idx;
    logic            rd_in_range;
    assign rd_idx      = sg_addr[WP_W-1:0];
    assign rd_in_range = (32'(sg_addr) < N);

    // Read happens every cycle; same-address write returns the old word.
    always_ff @(posedge clk) begin
        if (!reset_n)
            sg_val <= '0;
        else
            sg_val <= rd_in_range ? mem[rd_idx] : '0;
    end

endmodule
